parity_counter_9bit: RTL and testbench

- Free-running 9-bit binary up-counter with enable and synchronous clear.
- The counter drives a combinational 9-input odd/even parity generator with 74HC280 semantics.
- Used as a self-contained stimulus/parity source: the count value feeds the parity tree, and both are exported.
- Single clock domain, asynchronous active-low reset.

---
 rtl/parity_counter_9bit.sv | 85 ++++++++
 tb/tb_parity_counter_9bit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_counter_9bit.sv
`default_nettype none
// ============================================================================
// Module      : parity_counter_9bit
// Description : 9-bit up-counter with enable and synchronous clear that feeds
//               a combinational 74HC280-style odd/even parity generator.
//               Optional macro PARITY_CHECK_EN adds an even-parity checker
//               (parity_in / parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
module parity_counter_9bit #(
    parameter int unsigned          WIDTH       = 9,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             sclr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sigma_even,
    output logic             sigma_odd
`ifdef PARITY_CHECK_EN
    ,
    input  logic             parity_in,
    output logic             parity_err
`endif
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_odd;

    // Clear outranks enable; the add wraps naturally at 2^WIDTH.
    always_comb begin
        count_d = count_q;
        if (sclr) begin
            count_d = RESET_VALUE;
        end else if (enable) begin
            count_d = count_q + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign w_odd      = ^count_q;
    assign count      = count_q;
    assign tc         = &count_q;
    assign sigma_odd  = w_odd;
    assign sigma_even = ~w_odd;

`ifdef PARITY_CHECK_EN
    logic parity_err_q;
    logic parity_err_d;

    // A passing enabled comparison clears the flag; idle cycles hold it.
    always_comb begin
        parity_err_d = parity_err_q;
        if (sclr) begin
            parity_err_d = 1'b0;
        end else if (enable) begin
            parity_err_d = parity_in ^ w_odd;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_counter_9bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_counter_9bit
// Description : Directed plus randomized self-checking bench for
//               parity_counter_9bit against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_counter_9bit;

    logic       clk;
    logic       clr_n;
    logic       enable;
    logic       sclr;
    logic [8:0] count;
    logic       tc;
    logic       sigma_even;
    logic       sigma_odd;
`ifdef PARITY_CHECK_EN
    logic       parity_in;
    logic       parity_err;
    int         m_err;
`endif

    int total;
    int bad;
    int m_count;

    parity_counter_9bit #(
        .WIDTH       (9),
        .RESET_VALUE (9'd0)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .enable     (enable),
        .sclr       (sclr),
        .count      (count),
        .tc         (tc),
        .sigma_even (sigma_even),
        .sigma_odd  (sigma_odd)
`ifdef PARITY_CHECK_EN
        ,
        .parity_in  (parity_in),
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ones_in(input int v);
        int n;
        n = 0;
        for (int b = 0; b < 9; b++) begin
            if (((v >> b) & 1) == 1) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int odd;
        odd = ones_in(m_count) % 2;
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".tc"}, int'(tc), (m_count == 511) ? 1 : 0);
        chk({tag, ".odd"}, int'(sigma_odd), odd);
        chk({tag, ".even"}, int'(sigma_even), 1 - odd);
`ifdef PARITY_CHECK_EN
        chk({tag, ".perr"}, int'(parity_err), m_err);
`endif
    endtask

    // Advance one clock, update the reference model from the driven inputs,
    // then sample just after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
`ifdef PARITY_CHECK_EN
        if (!clr_n || sclr) m_err = 0;
        else if (enable) m_err = (int'(parity_in) + ones_in(m_count)) % 2;
`endif
        if (!clr_n)      m_count = 0;
        else if (sclr)   m_count = 0;
        else if (enable) m_count = (m_count + 1) % 512;
        #1;
        check_all(tag);
    endtask

    task automatic set_clean_parity();
`ifdef PARITY_CHECK_EN
        parity_in = (ones_in(m_count) % 2 == 1);
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_count = 0;
`ifdef PARITY_CHECK_EN
        m_err     = 0;
        parity_in = 1'b0;
`endif
        clr_n  = 1'b1;
        enable = 1'b1;
        sclr   = 1'b0;

        // Asynchronous reset with enable high and the clock running
        #1 clr_n = 1'b0;
        #2 check_all("reset_async");
        tick("reset_hold");
        tick("reset_hold");

        // Release and count 1, 2, 3
        clr_n = 1'b1;
        set_clean_parity();
        for (int i = 0; i < 3; i++) begin
            tick("count_up");
            set_clean_parity();
        end

        // Reach 7, hold for 10 cycles, then resume to 8
        for (int i = 0; i < 4; i++) begin
            tick("to_seven");
            set_clean_parity();
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick("hold");
        enable = 1'b1;
        set_clean_parity();
        tick("resume");

        // Reach 40, then sclr and enable together
        while (m_count != 40) begin
            set_clean_parity();
            tick("to_forty");
        end
        sclr = 1'b1;
        tick("sclr_wins");
        sclr = 1'b0;

        // Asynchronous reset pulse in the middle of a cycle
        for (int i = 0; i < 3; i++) begin
            set_clean_parity();
            tick("pre_async");
        end
        #2 clr_n = 1'b0;
        m_count = 0;
`ifdef PARITY_CHECK_EN
        m_err = 0;
`endif
        #1 check_all("async_pulse");
        clr_n = 1'b1;

        // Run up to terminal count and wrap
        while (m_count != 511) begin
            set_clean_parity();
            tick("to_wrap");
        end
        chk("wrap.tc_seen", int'(tc), 1);
        set_clean_parity();
        tick("wrap");

`ifdef PARITY_CHECK_EN
        // Inject a parity error at count 5, then a clean cycle
        while (m_count != 5) begin
            set_clean_parity();
            tick("to_five");
        end
        parity_in = (ones_in(m_count) % 2 == 0);
        tick("perr_set");
        set_clean_parity();
        tick("perr_clear");
`endif

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) < 7);
            sclr   = ($urandom_range(0, 19) == 0);
            clr_n  = ($urandom_range(0, 49) != 0);
`ifdef PARITY_CHECK_EN
            parity_in = ((ones_in(m_count) % 2 == 1) ^ ($urandom_range(0, 9) == 0));
`endif
            if (!clr_n) begin
                #0;
                m_count = 0;
`ifdef PARITY_CHECK_EN
                m_err = 0;
`endif
            end
            tick("random");
            clr_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
